// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned DEF_NUM_INSTR = 66;
    localparam int unsigned DEF_ADDR_W    = 7;
    localparam int unsigned INSTR_W       = 9;
    localparam int unsigned BR_OFF_W      = 6;
    localparam int unsigned CYC_W         = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_next.sv
// Next-PC selection and target range checking (purely combinational).
// Priority: halt > jump > branch > sequential. ADDR_W must exceed BR_OFF_W.
module pc_next
    import fetch_pkg::*;
#(
    parameter int unsigned NUM_INSTR = DEF_NUM_INSTR,
    parameter int unsigned ADDR_W    = DEF_ADDR_W
) (
    input  logic [ADDR_W-1:0]   address,
    input  logic                halt,
    input  logic                jump_en,
    input  logic [ADDR_W-1:0]   jump_target,
    input  logic                branch_en,
    input  logic [BR_OFF_W-1:0] branch_offset,
    output logic [ADDR_W-1:0]   next_addr_c,
    output logic                finish_c,
    output logic                range_hit_c
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_INSTR - 1);

    logic [ADDR_W-1:0] offset_ext;
    logic [ADDR_W-1:0] branch_tgt;

    // Branch target wraps modulo 2^ADDR_W; only the final range check matters.
    assign offset_ext = {{(ADDR_W-BR_OFF_W){branch_offset[BR_OFF_W-1]}}, branch_offset};
    assign branch_tgt = address + offset_ext;

    function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
        return 32'(a) >= NUM_INSTR;
    endfunction

    // Select next PC; an illegal target or running off the end finishes with PC held.
    always_comb begin
        next_addr_c = address;
        finish_c    = 1'b0;
        range_hit_c = 1'b0;
        if (halt) begin
            finish_c = 1'b1;
        end else if (jump_en) begin
            if (out_of_range(jump_target)) begin
                finish_c    = 1'b1;
                range_hit_c = 1'b1;
            end else begin
                next_addr_c = jump_target;
            end
        end else if (branch_en) begin
            if (out_of_range(branch_tgt)) begin
                finish_c    = 1'b1;
                range_hit_c = 1'b1;
            end else begin
                next_addr_c = branch_tgt;
            end
        end else if (address == LAST_ADDR) begin
            finish_c = 1'b1;
        end else begin
            next_addr_c = address + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: IDLE/RUN/DONE FSM driving the ROM address.
// Optional: define FETCH_CYCLE_COUNT_EN to add the cycle_count output.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned NUM_INSTR = DEF_NUM_INSTR,
    parameter int unsigned ADDR_W    = DEF_ADDR_W
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic                stall,
    input  logic                halt,
    input  logic                jump_en,
    input  logic [ADDR_W-1:0]   jump_target,
    input  logic                branch_en,
    input  logic [BR_OFF_W-1:0] branch_offset,
    output logic [ADDR_W-1:0]   address,
    output logic                fetch_valid,
    output logic                done,
    output logic                range_err
`ifdef FETCH_CYCLE_COUNT_EN
    ,
    output logic [CYC_W-1:0]    cycle_count
`endif
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] addr_d;
    logic              range_err_d;
    logic [ADDR_W-1:0] next_addr_c;
    logic              finish_c;
    logic              range_hit_c;

    pc_next #(
        .NUM_INSTR (NUM_INSTR),
        .ADDR_W    (ADDR_W)
    ) u_pc_next (
        .address       (address),
        .halt          (halt),
        .jump_en       (jump_en),
        .jump_target   (jump_target),
        .branch_en     (branch_en),
        .branch_offset (branch_offset),
        .next_addr_c   (next_addr_c),
        .finish_c      (finish_c),
        .range_hit_c   (range_hit_c)
    );

    // Fetch is live in RUN unless stalled; stall also masks all control inputs.
    assign fetch_valid = (state_q == RUN) && !stall;
    assign done        = (state_q == DONE);

    // State, PC and sticky range flag registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            address   <= '0;
            range_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            address   <= addr_d;
            range_err <= range_err_d;
        end
    end

    // Next-state logic; start is honoured only outside RUN.
    always_comb begin
        state_d     = state_q;
        addr_d      = address;
        range_err_d = range_err;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    addr_d      = '0;
                    range_err_d = 1'b0;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (finish_c) begin
                        state_d = DONE;
                        if (range_hit_c) begin
                            range_err_d = 1'b1;
                        end
                    end else begin
                        addr_d = next_addr_c;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_d     = RUN;
                    addr_d      = '0;
                    range_err_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
            end
        endcase
    end

`ifdef FETCH_CYCLE_COUNT_EN
    // Saturating count of RUN cycles (stalls included), cleared by an accepted start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cycle_count <= '0;
        end else if (start && (state_q != RUN)) begin
            cycle_count <= '0;
        end else if ((state_q == RUN) && (cycle_count != '1)) begin
            cycle_count <= cycle_count + CYC_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected fetch addresses are queued per scenario
// and popped whenever the DUT presents fetch_valid.
module tb_instr_fetch;

    localparam int unsigned NI = 66;
    localparam int unsigned AW = 7;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start;
    logic          stall;
    logic          halt;
    logic          jump_en;
    logic [AW-1:0] jump_target;
    logic          branch_en;
    logic [5:0]    branch_offset;
    logic [AW-1:0] address;
    logic          fetch_valid;
    logic          done;
    logic          range_err;
`ifdef FETCH_CYCLE_COUNT_EN
    logic [15:0]   cycle_count;
`endif

    int            n_cmp = 0;
    int            n_err = 0;
    logic [AW-1:0] exp_q[$];

    always #5 clock = ~clock;

    instr_fetch #(.NUM_INSTR(NI), .ADDR_W(AW)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .stall         (stall),
        .halt          (halt),
        .jump_en       (jump_en),
        .jump_target   (jump_target),
        .branch_en     (branch_en),
        .branch_offset (branch_offset),
        .address       (address),
        .fetch_valid   (fetch_valid),
        .done          (done),
        .range_err     (range_err)
`ifdef FETCH_CYCLE_COUNT_EN
        ,
        .cycle_count   (cycle_count)
`endif
    );

    task automatic clear_ctl();
        start = 1'b0; stall = 1'b0; halt = 1'b0; jump_en = 1'b0;
        jump_target = '0; branch_en = 1'b0; branch_offset = '0;
    endtask

    task automatic pulse_start();
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) exp_q.push_back(AW'(i));
    endtask

    task automatic test_reset();
        clear_ctl();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        n_cmp++; if (address !== 7'd0) begin n_err++; $display("FAIL reset_addr: got %0d want 0", address); end
        n_cmp++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL reset_fv: got %b want 0", fetch_valid); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (range_err !== 1'b0) begin n_err++; $display("FAIL reset_rerr: got %b want 0", range_err); end
        @(negedge clock); reset_n = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        n_cmp++; if (fetch_valid !== 1'b0 || address !== 7'd0 || done !== 1'b0) begin
            n_err++; $display("FAIL idle_wait: fv=%b addr=%0d done=%b want 0/0/0", fetch_valid, address, done);
        end
    endtask

    task automatic test_sequential();
        logic [AW-1:0] e;
        bit fin;
        int c65, cdone;
        fin = 0; c65 = -1; cdone = -1;
        exp_q.delete();
        push_range(0, int'(NI) - 1);
        pulse_start();
        #1;
        n_cmp++; if (fetch_valid !== 1'b1) begin n_err++; $display("FAIL start_latency: fv=%b want 1", fetch_valid); end
        for (int c = 0; c < 200; c++) begin
            start = (address == 7'd5);
            #1;
            if (fetch_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin n_err++; $display("FAIL seq_fetch: addr %0d fetched, none expected", address); end
                else begin
                    e = exp_q.pop_front();
                    if (address !== e) begin n_err++; $display("FAIL seq_fetch: got %0d want %0d", address, e); end
                end
                if (address == 7'(NI - 1)) c65 = c;
            end
            if (done) begin fin = 1; cdone = c; break; end
            @(negedge clock);
        end
        start = 1'b0;
        n_cmp++; if (!fin) begin n_err++; $display("FAIL seq_timeout: done never rose"); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL seq_left: %0d fetches missing, want 0", exp_q.size()); end
        n_cmp++; if (cdone - c65 != 1) begin n_err++; $display("FAIL seq_done_lat: %0d cycles, want 1", cdone - c65); end
        repeat (2) @(negedge clock);
        #1;
        n_cmp++; if (address !== 7'(NI - 1) || done !== 1'b1 || fetch_valid !== 1'b0) begin
            n_err++; $display("FAIL seq_hold: addr=%0d done=%b fv=%b want 65/1/0", address, done, fetch_valid);
        end
    endtask

    task automatic test_branch();
        int at_a[3]  = '{10, 3, 2};
        int off_a[3] = '{-4, 31, -5};
        logic [AW-1:0] tgt, e;
        bit fin, taken;
        for (int r = 0; r < 3; r++) begin
            tgt = AW'(at_a[r] + off_a[r]);
            fin = 0; taken = 0;
            exp_q.delete();
            push_range(0, at_a[r]);
            if (r < 2) exp_q.push_back(tgt);
            pulse_start();
            for (int c = 0; c < 100; c++) begin
                branch_en     = !taken && (address == AW'(at_a[r]));
                branch_offset = 6'(off_a[r]);
                halt          = taken && (r < 2) && (address == tgt);
                #1;
                if (fetch_valid) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin n_err++; $display("FAIL br_fetch: addr %0d fetched, none expected", address); end
                    else begin
                        e = exp_q.pop_front();
                        if (address !== e) begin n_err++; $display("FAIL br_fetch: got %0d want %0d", address, e); end
                    end
                    if (branch_en) taken = 1;
                end
                if (done) begin fin = 1; break; end
                @(negedge clock);
            end
            clear_ctl();
            n_cmp++; if (!fin || exp_q.size() != 0) begin
                n_err++; $display("FAIL br_end: fin=%b left=%0d want 1/0", fin, exp_q.size());
            end
            n_cmp++; if (address !== ((r < 2) ? tgt : AW'(at_a[r]))) begin
                n_err++; $display("FAIL br_addr: got %0d want %0d", address, (r < 2) ? tgt : AW'(at_a[r]));
            end
            n_cmp++; if (range_err !== (r == 2)) begin n_err++; $display("FAIL br_rerr: got %b want %b", range_err, r == 2); end
        end
        pulse_start();
        #1;
        n_cmp++; if (range_err !== 1'b0 || address !== 7'd0) begin
            n_err++; $display("FAIL rerr_clear: rerr=%b addr=%0d want 0/0", range_err, address);
        end
        halt = 1'b1;
        @(negedge clock); halt = 1'b0;
        #1;
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL halt_at0: done=%b want 1", done); end
    endtask

    task automatic test_priority();
        int       hlt_a[3] = '{1, 0, 0};
        int       jt_a[3]  = '{40, 40, 100};
        int       at_a[3]  = '{20, 20, 4};
        int       end_a[3] = '{20, 40, 4};
        logic [AW-1:0] e;
        bit fin, jumped;
        for (int r = 0; r < 3; r++) begin
            fin = 0; jumped = 0;
            exp_q.delete();
            push_range(0, at_a[r]);
            if (r == 1) exp_q.push_back(7'd40);
            pulse_start();
            for (int c = 0; c < 100; c++) begin
                jump_en       = !jumped && (address == AW'(at_a[r]));
                branch_en     = jump_en;
                branch_offset = 6'd1;
                jump_target   = AW'(jt_a[r]);
                halt          = (jump_en && hlt_a[r] != 0) || (jumped && address == 7'd40);
                #1;
                if (fetch_valid) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin n_err++; $display("FAIL pri_fetch: addr %0d fetched, none expected", address); end
                    else begin
                        e = exp_q.pop_front();
                        if (address !== e) begin n_err++; $display("FAIL pri_fetch: got %0d want %0d", address, e); end
                    end
                    if (jump_en) jumped = 1;
                end
                if (done) begin fin = 1; break; end
                @(negedge clock);
            end
            clear_ctl();
            n_cmp++; if (!fin || exp_q.size() != 0) begin
                n_err++; $display("FAIL pri_end: fin=%b left=%0d want 1/0", fin, exp_q.size());
            end
            n_cmp++; if (address !== AW'(end_a[r])) begin n_err++; $display("FAIL pri_addr: got %0d want %0d", address, end_a[r]); end
            n_cmp++; if (range_err !== (r == 2)) begin n_err++; $display("FAIL pri_rerr: got %b want %b", range_err, r == 2); end
        end
    endtask

    task automatic test_stall();
        logic [AW-1:0] e;
        bit fin;
        int scount;
        fin = 0; scount = 0;
        exp_q.delete();
        push_range(0, 8);
        pulse_start();
        for (int c = 0; c < 100; c++) begin
            clear_ctl();
            if (address == 7'd7 && scount < 3) begin
                stall = 1'b1; jump_en = 1'b1; jump_target = 7'd50;
            end
            halt = (address == 7'd8);
            #1;
            if (stall) begin
                n_cmp++; if (fetch_valid !== 1'b0 || address !== 7'd7) begin
                    n_err++; $display("FAIL stall_hold: fv=%b addr=%0d want 0/7", fetch_valid, address);
                end
                scount++;
            end
            if (fetch_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin n_err++; $display("FAIL stall_fetch: addr %0d fetched, none expected", address); end
                else begin
                    e = exp_q.pop_front();
                    if (address !== e) begin n_err++; $display("FAIL stall_fetch: got %0d want %0d", address, e); end
                end
            end
            if (done) begin fin = 1; break; end
            @(negedge clock);
        end
        clear_ctl();
        n_cmp++; if (!fin || exp_q.size() != 0 || scount != 3) begin
            n_err++; $display("FAIL stall_end: fin=%b left=%0d stalls=%0d want 1/0/3", fin, exp_q.size(), scount);
        end
        n_cmp++; if (address !== 7'd8) begin n_err++; $display("FAIL stall_addr: got %0d want 8", address); end
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] e;
        bit hit;
        hit = 0;
        exp_q.delete();
        push_range(0, 29);
        pulse_start();
        for (int c = 0; c < 100; c++) begin
            if (address == 7'd30) begin
                reset_n = 1'b0;
                #1;
                hit = 1;
                n_cmp++; if (address !== 7'd0 || fetch_valid !== 1'b0 || done !== 1'b0 || range_err !== 1'b0) begin
                    n_err++; $display("FAIL async_reset: addr=%0d fv=%b done=%b rerr=%b want 0/0/0/0",
                                      address, fetch_valid, done, range_err);
                end
                break;
            end
            #1;
            if (fetch_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin n_err++; $display("FAIL rst_fetch: addr %0d fetched, none expected", address); end
                else begin
                    e = exp_q.pop_front();
                    if (address !== e) begin n_err++; $display("FAIL rst_fetch: got %0d want %0d", address, e); end
                end
            end
            @(negedge clock);
        end
        n_cmp++; if (!hit || exp_q.size() != 0) begin
            n_err++; $display("FAIL rst_reach: hit=%b left=%0d want 1/0", hit, exp_q.size());
        end
        @(negedge clock); reset_n = 1'b1;
        pulse_start();
        #1;
        n_cmp++; if (address !== 7'd0 || fetch_valid !== 1'b1) begin
            n_err++; $display("FAIL restart: addr=%0d fv=%b want 0/1", address, fetch_valid);
        end
        halt = 1'b1;
        @(negedge clock); halt = 1'b0;
        #1;
        n_cmp++; if (done !== 1'b1 || address !== 7'd0) begin
            n_err++; $display("FAIL restart_halt: done=%b addr=%0d want 1/0", done, address);
        end
    endtask

`ifdef FETCH_CYCLE_COUNT_EN
    task automatic test_cycle_count();
        bit fin;
        int scount;
        fin = 0; scount = 0;
        pulse_start();
        for (int c = 0; c < 200; c++) begin
            stall = (address == 7'd20 && scount < 2);
            #1;
            if (stall) scount++;
            if (done) begin fin = 1; break; end
            @(negedge clock);
        end
        clear_ctl();
        n_cmp++; if (!fin || cycle_count !== 16'd68) begin
            n_err++; $display("FAIL cyc_count: fin=%b count=%0d want 1/68", fin, cycle_count);
        end
        repeat (2) @(negedge clock);
        #1;
        n_cmp++; if (cycle_count !== 16'd68) begin n_err++; $display("FAIL cyc_hold: got %0d want 68", cycle_count); end
        pulse_start();
        #1;
        n_cmp++; if (cycle_count !== 16'd0) begin n_err++; $display("FAIL cyc_clear: got %0d want 0", cycle_count); end
        halt = 1'b1;
        @(negedge clock); halt = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_priority();
        test_stall();
        test_reset_mid();
`ifdef FETCH_CYCLE_COUNT_EN
        test_cycle_count();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench time limit reached, want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter NUM_INSTR, default 66: number of valid program words; legal addresses are 0..NUM_INSTR-1.
REQ-002 Parameter ADDR_W, default 7: program counter and ROM address width.
REQ-003 clock  input  1  single clock; all state changes on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle pulse that begins program execution from address 0.
REQ-006 stall  input  1  holds the PC and suppresses fetch_valid while high.
REQ-007 halt  input  1  decoder reports a halt instruction at the current address.
REQ-008 jump_en  input  1  absolute jump request.
REQ-009 jump_target  input  ADDR_W  absolute jump destination.
REQ-010 branch_en  input  1  relative branch request.
REQ-011 branch_offset  input  6  signed two's-complement branch offset (-32..+31).
REQ-012 address  output  ADDR_W  registered PC; drives the instruction ROM address.
REQ-013 fetch_valid  output  1  the instruction at address is to be consumed this cycle.
REQ-014 done  output  1  the program has finished; level signal.
REQ-015 range_err  output  1  sticky flag: a jump or branch targeted an address >= NUM_INSTR.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-017 IDLE: address=0, fetch_valid=0, done=0; start moves the FSM to RUN at the next edge with address=0.
REQ-018 RUN: fetch_valid = !stall (combinational); control inputs are sampled only on edges where fetch_valid=1.
REQ-019 Next-PC priority when fetch_valid=1: halt > jump_en > branch_en > sequential (address+1).
REQ-020 halt: FSM goes to DONE and address holds.
REQ-021 jump: address <= jump_target.
REQ-022 branch: address <= address + sign-extended branch_offset, computed modulo 2^ADDR_W (wrap-around is legal).
REQ-023 If a computed jump or branch target is >= NUM_INSTR, the FSM SHALL go to DONE, set range_err, and leave address unchanged.
REQ-024 A sequential advance from address NUM_INSTR-1 SHALL go to DONE with address held at NUM_INSTR-1.
REQ-025 stall=1 in RUN SHALL hold address and state, and SHALL mask halt, jump and branch.
REQ-026 DONE: done=1, fetch_valid=0; start returns the FSM to RUN with address=0 and clears range_err.
REQ-027 start SHALL be ignored in RUN.
REQ-028 Latency from start to the first fetch_valid SHALL be 1 cycle.

Reset
REQ-029 reset_n=0 SHALL immediately force IDLE, address=0, done=0, range_err=0 and fetch_valid=0, regardless of the current state.
REQ-030 After release, the FSM SHALL wait in IDLE for start.

Configuration
REQ-031 With FETCH_CYCLE_COUNT_EN defined, a 16-bit output cycle_count SHALL count RUN cycles (stalled cycles included), clear on start and on reset, saturate at 16'hFFFF, and hold in DONE.
REQ-032 Without FETCH_CYCLE_COUNT_EN, the cycle_count port and its counter SHALL NOT exist.

Structure
REQ-033 Package fetch_pkg SHALL hold the state enum, the ADDR_W and INSTR_W (9) defaults, and the branch-offset width (6).
REQ-034 Next-PC selection and range checking SHALL live in one combinational sub-module, pc_next, instantiated once.

Verification
REQ-035 Reset, then start; no control inputs -> address runs 0..65 with fetch_valid high, done=1 one cycle after address=65, address holds at 65.
REQ-036 At address=10: branch_en with offset -4 -> address=6; at address=3: offset +31 -> address=34; at address=2: offset -5 -> target 125 >= 66 -> DONE with range_err=1 and address=2.
REQ-037 jump_en, branch_en and halt all high at address=20 -> DONE, address=20; the same test with halt low and jump_target=40 -> address=40.
REQ-038 stall high for 3 cycles at address=7 while jump_en is asserted -> address stays 7, fetch_valid=0 throughout, jump ignored.
REQ-039 reset_n dropped mid-RUN at address=30 -> IDLE and address=0 immediately, without waiting for a clock edge; start -> restarts from 0.
REQ-040 With FETCH_CYCLE_COUNT_EN defined: full run with 2 stall cycles -> cycle_count=68 in DONE, and it clears on the next start.
